// File: rtl/imem_loader.sv
// UART-driven loader: parses A5 | N[15:0] | N big-endian words | checksum,
// writes words into instruction memory and answers the host with ACK/NAK.
module imem_loader #(
   parameter int          ADDR_WIDTH = 8,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
   parameter logic [23:0] TIMEOUT    = 24'd5_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   input  logic                  tx_busy,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]           wr_data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   localparam logic [7:0]  ACK   = 8'h06;
   localparam logic [7:0]  NAK   = 8'h15;
   localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

   typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHK, RESP} state_t;

   state_t                state;
   logic [7:0]            len_hi;
   logic [ADDR_WIDTH:0]   len;
   logic [ADDR_WIDTH:0]   word_cnt;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [1:0]            byte_idx;
   logic [23:0]           shift;
   logic [7:0]            chk;
   logic [23:0]           idle_cnt;
   logic                  ack;

   logic [15:0] n_words;
   logic [7:0]  sum_next;
   logic        in_frame;
   logic        timed_out;

   assign n_words   = {len_hi, rx_data};
   assign sum_next  = chk + rx_data;
   assign in_frame  = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CHK);
   // A byte arriving on the last allowed cycle wins over the timeout.
   assign timed_out = in_frame && !rx_valid && (idle_cnt == TIMEOUT - 24'd1);

   // NOTE: every register here is state, so all assignments are non-blocking;
   // the instruction memory itself lives outside and is never reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         len_hi    <= '0;
         len       <= '0;
         word_cnt  <= '0;
         next_addr <= '0;
         byte_idx  <= '0;
         shift     <= '0;
         chk       <= '0;
         idle_cnt  <= '0;
         ack       <= 1'b0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         wr_en    <= 1'b0;
         tx_valid <= 1'b0;
         if (in_frame)
            idle_cnt <= rx_valid ? 24'd0 : idle_cnt + 24'd1;

         if (timed_out) begin
            ack   <= 1'b0;
            state <= RESP;
         end else begin
            case (state)
               IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
                  done      <= 1'b0;
                  error     <= 1'b0;
                  cpu_hold  <= 1'b1;
                  chk       <= '0;
                  byte_idx  <= '0;
                  word_cnt  <= '0;
                  next_addr <= '0;
                  wr_addr   <= '0;
                  idle_cnt  <= '0;
                  state     <= LEN_HI;
               end
               LEN_HI: if (rx_valid) begin
                  len_hi <= rx_data;
                  state  <= LEN_LO;
               end
               LEN_LO: if (rx_valid) begin
                  if (n_words == 16'd0 || {1'b0, n_words} > DEPTH) begin
                     ack   <= 1'b0;
                     state <= RESP;
                  end else begin
                     len   <= n_words[ADDR_WIDTH:0];
                     state <= DATA;
                  end
               end
               DATA: if (rx_valid) begin
                  chk      <= sum_next;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     wr_en     <= 1'b1;
                     wr_addr   <= next_addr;
                     wr_data   <= {shift, rx_data};
                     next_addr <= next_addr + 1'b1;
                     word_cnt  <= word_cnt + 1'b1;
                     if (word_cnt == len - 1'b1)
                        state <= CHK;
                  end else begin
                     shift <= {shift[15:0], rx_data};
                  end
               end
               CHK: if (rx_valid) begin
                  ack   <= (sum_next == 8'd0);
                  state <= RESP;
               end
               RESP: if (!tx_busy) begin
                  tx_valid <= 1'b1;
                  tx_data  <= ack ? ACK : NAK;
                  if (ack) begin
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     error <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and responses are queued
// when a frame is built and checked as the DUT emits them.
module tb_imem_loader;

   localparam int          AW = 8;
   localparam logic [23:0] TO = 24'd200;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        tx_busy = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        error;

   imem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_busy(tx_busy), .tx_data(tx_data), .tx_valid(tx_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  stim[$];
   logic [31:0] words[$];
   logic [39:0] exp_wr[$];
   logic [7:0]  exp_tx[$];
   int wr_pushed = 0, wr_seen = 0, tx_pushed = 0, tx_seen = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: every write and response must match the queue head.
   always @(negedge clk) begin
      if (reset) begin
         if (wr_en) begin
            wr_seen++;
            if (exp_wr.size() == 0) check("wr_extra", wr_seen, wr_pushed);
            else begin
               logic [39:0] e;
               e = exp_wr.pop_front();
               check("wr_addr", wr_addr, e[39:32]);
               check("wr_data", wr_data, e[31:0]);
            end
         end
         if (tx_valid) begin
            tx_seen++;
            if (exp_tx.size() == 0) check("tx_extra", tx_seen, tx_pushed);
            else begin
               logic [7:0] t;
               t = exp_tx.pop_front();
               check("tx_data", tx_data, t);
               check("tx_busy_low", tx_busy, 0);
               check("hold_at_tx", cpu_hold, (t == 8'h15));
            end
         end
      end
   end

   // Builds a frame from 'words' into stim and queues the expected outcome.
   task automatic push_frame(input logic [15:0] len_field, input bit corrupt,
                             input bit send_chk, input bit expect_ack);
      logic [7:0] sum, c;
      logic [31:0] w;
      sum = 8'd0;
      stim.push_back(8'hA5);
      stim.push_back(len_field[15:8]);
      stim.push_back(len_field[7:0]);
      for (int i = 0; i < words.size(); i++) begin
         w = words[i];
         for (int b = 3; b >= 0; b--) begin
            stim.push_back(w[8*b +: 8]);
            sum = sum + w[8*b +: 8];
         end
         exp_wr.push_back({8'(i), w});
         wr_pushed++;
      end
      if (send_chk) begin
         c = 8'd0 - sum;
         if (corrupt) c = c + 8'd1;
         stim.push_back(c);
      end
      exp_tx.push_back(expect_ack ? 8'h06 : 8'h15);
      tx_pushed++;
   endtask

   task automatic send_stim();
      for (int i = 0; i < stim.size(); i++) begin
         @(negedge clk);
         rx_data  = stim[i];
         rx_valid = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      stim.delete();
   endtask

   task automatic wait_resp();
      for (int i = 0; i < 4 * int'(TO) && exp_tx.size() != 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("resp_pending", exp_tx.size(), 0);
      check("wr_pending", exp_wr.size(), 0);
   endtask

   task automatic check_flags(input bit ack);
      check("done", done, ack);
      check("error", error, !ack);
      check("cpu_hold", cpu_hold, !ack);
   endtask

   task automatic good_pair();
      words.delete();
      words.push_back(32'h3C084000);
      words.push_back(32'h21080008);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cpu_hold", cpu_hold, 1);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      reset = 1'b1;

      // Leading garbage then a good two-word frame.
      stim.push_back(8'h00); stim.push_back(8'hFF); stim.push_back(8'h12);
      good_pair();
      push_frame(16'd2, 1'b0, 1'b1, 1'b1);
      send_stim();
      wait_resp();
      check_flags(1'b1);

      // Bad checksum: words still land, then NAK.
      good_pair();
      push_frame(16'd2, 1'b1, 1'b1, 1'b0);
      send_stim();
      wait_resp();
      check_flags(1'b0);

      // A good frame recovers from the error.
      good_pair();
      push_frame(16'd2, 1'b0, 1'b1, 1'b1);
      send_stim();
      wait_resp();
      check_flags(1'b1);

      // Length errors: zero and one past depth.
      words.delete();
      push_frame(16'd0, 1'b0, 1'b0, 1'b0);
      send_stim();
      wait_resp();
      check_flags(1'b0);
      push_frame(16'h0101, 1'b0, 1'b0, 1'b0);
      send_stim();
      wait_resp();
      check_flags(1'b0);

      // Timeout mid-word while the transmitter is busy.
      tx_busy = 1'b1;
      stim.push_back(8'hA5); stim.push_back(8'h00); stim.push_back(8'h01);
      stim.push_back(8'h3C); stim.push_back(8'h08);
      send_stim();
      repeat (int'(TO) + 20) @(negedge clk);
      check("to_hold_busy", cpu_hold, 1);
      check("to_err_deferred", error, 0);
      exp_tx.push_back(8'h15);
      tx_pushed++;
      tx_busy = 1'b0;
      wait_resp();
      check_flags(1'b0);
      repeat (5) @(negedge clk);

      // Full-depth frame, back-to-back bytes, sync value inside the data.
      words.delete();
      for (int i = 0; i < 256; i++) words.push_back((i == 5) ? 32'hA5A5A5A5 : $urandom);
      push_frame(16'd256, 1'b0, 1'b1, 1'b1);
      send_stim();
      wait_resp();
      check_flags(1'b1);

      // Reset after the third word of an eight-word frame.
      words.delete();
      for (int i = 0; i < 3; i++) words.push_back($urandom);
      push_frame(16'd8, 1'b0, 1'b0, 1'b0);
      void'(exp_tx.pop_back());
      tx_pushed--;
      send_stim();
      repeat (2) @(negedge clk);
      check("mid_wr_pending", exp_wr.size(), 0);
      reset = 1'b0;
      #1;
      check("mid_rst_hold", cpu_hold, 1);
      check("mid_rst_done", done, 0);
      check("mid_rst_wr_addr", wr_addr, 0);
      @(negedge clk);
      reset = 1'b1;
      good_pair();
      push_frame(16'd2, 1'b0, 1'b1, 1'b1);
      send_stim();
      wait_resp();
      check_flags(1'b1);

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
